// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//
// Memory-side responder for the core's SRAM-like data port. Loads and stores
// are accepted with the req/addr_ok handshake and applied to an internal word
// array. Every accepted request gets exactly one data_ok pulse DELAY cycles
// later, in acceptance order. The pulse carries the read word for loads and
// zero for stores.
//
// Handshake: a request transfers on a rising edge where data_sram_req and
// data_sram_addr_ok are both high. addr_ok is combinational and does not
// depend on req. The initiator may drop req before it is accepted. data_ok is
// a one-cycle pulse with no ready; the initiator must always take it.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   data_sram_req       : request valid
//   data_sram_wr        : 1 = store, 0 = load
//   data_sram_size      : 0 byte, 1 half, 2/3 word (only used for misalign check)
//   data_sram_wstrb     : store byte enables (authoritative for writes)
//   data_sram_addr      : byte address; word index is addr[AW+1:2]
//   data_sram_wdata     : lane-replicated store data
//   stall_in            : forces addr_ok low while high
//   data_sram_addr_ok   : request may be accepted this cycle
//   data_sram_data_ok   : one-cycle in-order response pulse
//   data_sram_rdata     : load word, meaningful only with data_ok
//   misalign_err        : sticky flag for misaligned accepted requests
// -----------------------------------------------------------------------------
module data_sram_resp #(
   parameter int AW      = 10,
   parameter int DELAY   = 2,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   input  logic        stall_in,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        misalign_err
);

   localparam int CW = $clog2(MAX_OUT + 1);

   logic [31:0]      r_mem [0:(1<<AW)-1];
   logic [CW-1:0]    r_out_cnt;
   logic [DELAY-1:0] r_pipe_vld;
   logic [31:0]      r_pipe_word [0:DELAY-1];
   logic             r_misalign;

   logic             w_accept;
   logic [AW-1:0]    w_idx;
   logic [31:0]      w_rd_word;
   logic             w_misalign;
   logic             w_unused;

   // Upper address bits alias onto the same words.
   assign w_idx    = data_sram_addr[AW+1:2];
   assign w_unused = &{1'b0, data_sram_addr[31:AW+2]};

   // No bypass from a retiring response: a full pipeline frees a slot only
   // after the data_ok edge has decremented the count.
   assign data_sram_addr_ok = !stall_in && (r_out_cnt < CW'(MAX_OUT));

   // Nothing is accepted while reset is asserted, so no store lands and no
   // response is launched during reset.
   assign w_accept = data_sram_req && data_sram_addr_ok && !reset;

   // Array read is combinational on the current contents, so a load sees all
   // stores accepted on earlier edges. Stores respond with a zero word.
   assign w_rd_word = data_sram_wr ? 32'h0 : r_mem[w_idx];

   // size 3 is checked like a word access.
   assign w_misalign = ((data_sram_size == 2'd1) && data_sram_addr[0]) ||
                       (data_sram_size[1] && (data_sram_addr[1:0] != 2'b00));

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (w_accept && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i]) begin
               r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // Response shift register. Words only advance alongside a valid, so the
   // last stage (driving rdata) holds its value between responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < DELAY; i++) begin
            r_pipe_word[i] <= 32'h0;
         end
      end else begin
         r_pipe_vld[0] <= w_accept;
         if (w_accept) begin
            r_pipe_word[0] <= w_rd_word;
         end
         for (int i = 1; i < DELAY; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            if (r_pipe_vld[i-1]) begin
               r_pipe_word[i] <= r_pipe_word[i-1];
            end
         end
      end
   end

   // Outstanding count: acceptance and retirement in one cycle cancel.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_cnt <= '0;
      end else if (w_accept && !data_sram_data_ok) begin
         r_out_cnt <= r_out_cnt + CW'(1);
      end else if (!w_accept && data_sram_data_ok) begin
         r_out_cnt <= r_out_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (w_accept && w_misalign) begin
         r_misalign <= 1'b1;
      end
   end

   assign data_sram_data_ok = r_pipe_vld[DELAY-1];
   assign data_sram_rdata   = r_pipe_word[DELAY-1];
   assign misalign_err      = r_misalign;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//
// Bench for data_sram_resp (AW=10, DELAY=2, MAX_OUT=2). A reference word
// array is updated at acceptance time; each acceptance pushes the expected
// response word and the expected data_ok cycle into queues, which a monitor
// pops and compares whenever data_ok is seen.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

   localparam int AW      = 10;
   localparam int DELAY   = 2;
   localparam int MAX_OUT = 2;

   logic        clk;
   logic        reset;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        stall_in;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        misalign_err;

   data_sram_resp #(.AW(AW), .DELAY(DELAY), .MAX_OUT(MAX_OUT)) dut (
      .clk               (clk),
      .reset             (reset),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .stall_in          (stall_in),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .misalign_err      (misalign_err)
   );

   // ---------------- clock / reset / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [31:0] model_mem [int];

   always @(negedge clk) begin
      if (!reset && data_sram_data_ok) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_data_ok: cycle %0d rdata=%h, no response pending", cyc, data_sram_rdata);
         end else begin
            logic [31:0] w;
            int          c;
            w = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            if (data_sram_rdata !== w || cyc != c) begin
               n_fail++;
               $display("FAIL resp: got rdata=%h at cycle %0d, expected rdata=%h at cycle %0d",
                        data_sram_rdata, cyc, w, c);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge. Holds req until accepted (bounded),
   // updates the reference array and pushes the expected response.
   task automatic issue(input logic wr, input logic [1:0] size, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata, output int acc_cyc);
      int waited;
      bit done;
      int idx;
      waited  = 0;
      done    = 0;
      acc_cyc = -1;
      data_sram_req   = 1'b1;
      data_sram_wr    = wr;
      data_sram_size  = size;
      data_sram_wstrb = strb;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
      while (!done) begin
         @(negedge clk);
         if (data_sram_addr_ok) begin
            acc_cyc = cyc;
            idx = int'(addr[AW+1:2]);
            if (wr) begin
               logic [31:0] m;
               m = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
               for (int i = 0; i < 4; i++) begin
                  if (strb[i]) m[8*i +: 8] = wdata[8*i +: 8];
               end
               model_mem[idx] = m;
               exp_q.push_back(32'h0);
            end else begin
               exp_q.push_back(model_mem[idx]);
            end
            exp_cyc_q.push_back(cyc + DELAY);
            done = 1;
         end else if (waited >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: addr=%h not accepted in 20 cycles, required acceptance", addr);
            done = 1;
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
      data_sram_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         @(posedge clk);
         waited++;
      end
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d responses still pending, required 0", exp_q.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (data_sram_data_ok !== 1'b0 || data_sram_rdata !== 32'h0 ||
          misalign_err !== 1'b0 || data_sram_addr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: data_ok=%b rdata=%h misalign=%b addr_ok=%b, required 0 00000000 0 1",
                  data_sram_data_ok, data_sram_rdata, misalign_err, data_sram_addr_ok);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_word();
      int a0, a1;
      issue(1'b1, 2'd2, 4'hF, 32'h10, 32'h12345678, a0);
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a1);
      n_checks++;
      if (a1 != a0 + 1) begin
         n_fail++;
         $display("FAIL word_accept: load accepted cycle %0d, required %0d", a1, a0 + 1);
      end
      drain();
      n_checks++;
      if (data_sram_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL word_rdata_hold: rdata=%h, required 12345678", data_sram_rdata);
      end
   endtask

   task automatic test_byte();
      int a;
      issue(1'b1, 2'd0, 4'b0100, 32'h12, 32'hAAAAAAAA, a);
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a);
      drain();
      n_checks++;
      if (data_sram_rdata !== 32'h12AA5678 || misalign_err !== 1'b0) begin
         n_fail++;
         $display("FAIL byte_store: rdata=%h misalign=%b, required 12aa5678 0",
                  data_sram_rdata, misalign_err);
      end
   endtask

   task automatic test_backpressure();
      int a0, a1, a2;
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a0);
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a1);
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a2);
      n_checks++;
      if (a1 != a0 + 1 || a2 != a0 + 3) begin
         n_fail++;
         $display("FAIL backpressure_accept: accepts at +%0d,+%0d, required +1,+3", a1 - a0, a2 - a0);
      end
      drain();
   endtask

   task automatic test_stall_misalign();
      int a;
      stall_in        = 1'b1;
      data_sram_req   = 1'b1;
      data_sram_wr    = 1'b0;
      data_sram_size  = 2'd2;
      data_sram_addr  = 32'h10;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (data_sram_addr_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL stall: addr_ok=%b data_ok=%b, required 0 0", data_sram_addr_ok, data_sram_data_ok);
         end
         @(posedge clk);
         #1;
      end
      stall_in      = 1'b0;
      data_sram_req = 1'b0;
      issue(1'b1, 2'd1, 4'b0110, 32'h11, 32'hBEEFBEEF, a);
      n_checks++;
      if (misalign_err !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_set: misalign=%b, required 1", misalign_err);
      end
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a);
      drain();
      idle(3);
      n_checks++;
      if (misalign_err !== 1'b1 || data_sram_rdata !== 32'h12EFBE78) begin
         n_fail++;
         $display("FAIL misalign_sticky: misalign=%b rdata=%h, required 1 12efbe78",
                  misalign_err, data_sram_rdata);
      end
   endtask

   task automatic test_random();
      int a;
      logic [31:0] addr;
      // Seed a 16-word region, then mix loads/stores with aliased upper bits.
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 2'd2, 4'hF, 32'h100 + 32'(4 * i), $urandom, a);
      end
      for (int i = 0; i < 40; i++) begin
         addr = {$urandom_range(0, 1023) << 12} | (32'h100 + 32'(4 * $urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1) begin
            issue(1'b1, 2'd2, 4'($urandom_range(0, 15)), addr, $urandom, a);
         end else begin
            issue(1'b0, 2'd2, 4'h0, addr, 32'h0, a);
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      int a;
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a);
      // Cycle a+1: reset kills the in-flight load.
      reset = 1'b1;
      exp_q.delete();
      exp_cyc_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (data_sram_data_ok !== 1'b0 || dut.r_out_cnt !== '0 ||
          data_sram_addr_ok !== 1'b1 || misalign_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midflight: data_ok=%b out_cnt=%0d addr_ok=%b misalign=%b, required 0 0 1 0",
                  data_sram_data_ok, dut.r_out_cnt, data_sram_addr_ok, misalign_err);
      end
      idle(4);
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_midflight_rdata: rdata=%h, required 00000000", data_sram_rdata);
      end
      // Memory survives reset.
      issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0, a);
      drain();
   endtask

   initial begin
      reset           = 1'b1;
      data_sram_req   = 1'b0;
      data_sram_wr    = 1'b0;
      data_sram_size  = 2'd0;
      data_sram_wstrb = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      stall_in        = 1'b0;

      test_reset();
      test_word();
      test_byte();
      test_backpressure();
      test_stall_misalign();
      test_random();
      test_reset_midflight();

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_queue: %0d responses never delivered, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
